bit_serial_adder: RTL

Parametrised multi-cycle adder/subtractor, the successor to the single-cycle half/full adders in the tile. It processes DIGIT bits per clock across WIDTH-bit operands, using ripple carry between digits. It has a valid/ready handshake on both sides, an optional accumulate mode, and status flags (carry, signed overflow, zero). It sits between the ui_in/uio_in operand capture logic and the uo_out result mux.

---
 rtl/bit_serial_adder.sv | 109 ++++++++++
 1 files changed

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per cycle with ripple carry between digits.
// Valid/ready on both sides, optional accumulate mode, and carry/overflow/zero flags.
module bit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SR_W  = (WIDTH > DIGIT) ? WIDTH - DIGIT : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, acc_q, b_eff;
  logic [SR_W-1:0]  res_sr, sr_next;
  logic [WIDTH-1:0] res_next;
  logic [DIGIT:0]   dsum;
  logic [CNT_W-1:0] cnt;
  logic             carry, a_msb, b_msb;

  function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign b_eff     = (acc ? acc_q : b) ^ {WIDTH{sub}};
  assign dsum      = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + (DIGIT+1)'(carry);

  // The partial result keeps only the upper WIDTH-DIGIT bits; the newest digit lands on top.
  generate
    if (DIGIT < WIDTH) begin : g_multi
      assign res_next = {dsum[DIGIT-1:0], res_sr};
      assign sr_next  = res_next[WIDTH-1:DIGIT];
    end else begin : g_single
      assign res_next = dsum[DIGIT-1:0];
      assign sr_next  = res_sr;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res_sr <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b_eff;
            carry <= sub;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            state <= RUN;
          end
        end
        RUN: begin
          op_a   <= op_a >> DIGIT;
          op_b   <= op_b >> DIGIT;
          carry  <= dsum[DIGIT];
          res_sr <= sr_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            sum   <= res_next;
            cout  <= dsum[DIGIT];
            ovf   <= add_ovf(a_msb, b_msb, res_next[WIDTH-1]);
            zero  <= (res_next == '0);
            acc_q <= res_next;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
